unified_mem_ctrl: RTL and testbench
===================================

Name: unified_mem_ctrl

Overview:
- Single-port unified instruction/data memory with a controller for the mips core.
- Replaces the split instrmem/datamem pair at top level.
- Arbitrates the fetch port and the load/store port onto one word array, inserting a parametrised number of wait states.
- Both requesters see a req/ack handshake, so the core stalls on contention or slow memory.

Parameters:
- DATA_W, 32, word width in bits.
- DEPTH, 256, number of words; power of two, minimum 4.
- WAIT_STATES, 1, extra cycles between acceptance and response; range 0..15.
- INIT_FILE, "", hex file loaded with $readmemh when non-empty.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- i_req  in  1  fetch request; held until i_ack.
- i_addr  in  32  fetch byte address; stable while i_req.
- i_rdata  out  DATA_W  fetched word; valid when i_ack.
- i_ack  out  1  one-cycle fetch completion pulse.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = store, 0 = load; stable while d_req.
- d_addr  in  32  data byte address; stable while d_req.
- d_wdata  in  DATA_W  store data; stable while d_req.
- d_rdata  out  DATA_W  load data; valid when d_ack.
- d_ack  out  1  one-cycle data completion pulse.
- addr_err  out  1  pulses with ack when the accepted address is out of range.
- busy  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Word index = addr[log2(DEPTH)+1:2]; addr[1:0] ignored.
- Address is out of range when addr >= 4*DEPTH.
  - Out-of-range load returns 0; out-of-range store is dropped; addr_err=1 in the ack cycle.
- FSM states:
  - IDLE: requests sampled only here.
    - d_req=1 -> grant D, load wait counter with WAIT_STATES, go to WAIT (or RESP if WAIT_STATES=0).
    - Else i_req=1 -> same, granting I.
    - Data has fixed priority over fetch.
  - WAIT: decrement counter each cycle; at 0 go to RESP. Memory read (or write commit) happens on this transition edge.
  - RESP: assert the granted ack for exactly one cycle with registered rdata; go to IDLE.
- Latency: ack is high in cycle N+WAIT_STATES+1 after req is sampled in IDLE cycle N.
  - Back-to-back throughput: one access per WAIT_STATES+2 cycles.
- Grant, address, we and wdata are latched at acceptance; changes on the inputs after acceptance have no effect.
- Requester must drop req, or present a new access, in the cycle after ack. A req still high in the cycle after ack is treated as a new request.
- Simultaneous i_req and d_req: D served first. I is accepted in the IDLE cycle after D's RESP, with no extra bubble beyond that IDLE cycle.
- Store then load to the same word: the load returns the stored value (write commits before RESP).
- i_rdata and d_rdata hold their last acked value between acks. The non-granted port's rdata is unchanged.
- Reset values: i_ack=0, d_ack=0, i_rdata=0, d_rdata=0, addr_err=0, busy=0, state IDLE, counter 0.
- Reset mid-operation forces IDLE with no ack. A store whose commit edge coincides with rst_n=0 is not written. Memory array contents are not cleared by reset.

Optional Feature:
- UMEM_FETCH_BUF_EN enables a one-entry fetch buffer (tag = word index, data, valid).
- With the macro:
  - In IDLE with d_req=0, i_req=1 and a buffer hit -> i_ack and i_rdata in the next cycle. No memory access, no WAIT, busy stays 0.
  - Misses fill the buffer when the access completes.
  - Any store to the buffered word index, or reset, clears valid.
  - d_req still has priority over a hit.
- Without the macro: every fetch goes through the FSM, and no buffer state or logic exists.

Test Plan:
- WAIT_STATES=2, INIT word 3 = 0xDEADBEEF; i_req at i_addr=0x0C in cycle 0 -> i_ack=1 in cycle 3 with i_rdata=0xDEADBEEF; busy high in cycles 1-3.
- d_req store 0x12345678 to 0x20, then load 0x20 -> second d_ack returns d_rdata=0x12345678; i_rdata unchanged.
- i_req and d_req both asserted in the same cycle, WAIT_STATES=1 -> d_ack in cycle 2, i_ack in cycle 5; no overlap of acks.
- DEPTH=256, load at 0x400 -> d_ack with d_rdata=0 and addr_err=1; store 0xFFFFFFFF at 0x400 leaves words 0 and 255 unchanged.
- Store 0xAA to 0x08 with rst_n=0 asserted at the commit edge -> no ack; subsequent load of 0x08 returns the original INIT value.
- UMEM_FETCH_BUF_EN, fetch 0x04 twice -> second i_ack one cycle after req, busy=0. After a store of 0x55 to 0x04, the next fetch takes the full latency and returns 0x55.

Source files
------------

// File: rtl/unified_mem_ctrl.sv
// unified_mem_ctrl: single-port unified I/D memory with wait-state FSM; define UMEM_FETCH_BUF_EN for a one-entry fetch buffer
module unified_mem_ctrl #(
  parameter int    DATA_W      = 32,
  parameter int    DEPTH       = 256,
  parameter int    WAIT_STATES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              addr_err,
  output logic              busy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  logic [DATA_W-1:0] mem [DEPTH];
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic sel_dat_q, sel_dat_d, we_q, we_d, oor_q, oor_d;
  logic [AW-1:0] idx_q, idx_d, i_idx, d_idx, a_idx;
  logic [DATA_W-1:0] wdata_q, wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic [DATA_W-1:0] a_wdata, rd_word;
  logic idle, i_oor, d_oor, fetch_ok, accept, commit, mem_we, a_dat, a_we, a_oor, fb_ack;
  assign i_idx = i_addr[AW+1:2];
  assign d_idx = d_addr[AW+1:2];
  assign i_oor = (i_addr >> (AW + 2)) != 32'd0;
  assign d_oor = (d_addr >> (AW + 2)) != 32'd0;
  assign idle = state_q == S_IDLE;
  assign accept = idle && (d_req || (i_req && fetch_ok));
  assign a_dat = idle ? d_req : sel_dat_q;
  assign a_idx = idle ? (d_req ? d_idx : i_idx) : idx_q;
  assign a_oor = idle ? (d_req ? d_oor : i_oor) : oor_q;
  assign a_we = idle ? d_req && d_we : we_q;
  assign a_wdata = idle ? d_wdata : wdata_q;
  assign commit = (accept && WAIT_STATES == 0) || (state_q == S_WAIT && cnt_q == 4'd1);
  assign mem_we = rst_n && commit && a_we && !a_oor;
  assign rd_word = a_oor ? '0 : mem[a_idx];
  assign busy = !idle;
  assign i_ack = (state_q == S_RESP && !sel_dat_q) || fb_ack;
  assign d_ack = state_q == S_RESP && sel_dat_q;
  assign addr_err = state_q == S_RESP && oor_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
`ifdef UMEM_FETCH_BUF_EN
  logic fb_valid_q, fb_valid_d, hit_q, hit_d, fb_hit;
  logic [AW-1:0] fb_tag_q, fb_tag_d;
  logic [DATA_W-1:0] fb_data_q, fb_data_d;
  assign fb_hit = fb_valid_q && !i_oor && fb_tag_q == i_idx;
  assign hit_d = idle && !d_req && i_req && !hit_q && fb_hit;
  assign fetch_ok = !hit_q && !fb_hit;
  assign fb_ack = hit_q;
  always_comb begin
    fb_valid_d = fb_valid_q;
    fb_tag_d = fb_tag_q;
    fb_data_d = fb_data_q;
    if (commit && !a_dat && !a_oor) begin
      fb_valid_d = 1'b1;
      fb_tag_d = a_idx;
      fb_data_d = rd_word;
    end
    if (mem_we && a_idx == fb_tag_q) fb_valid_d = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fb_valid_q <= 1'b0;
      hit_q <= 1'b0;
      fb_tag_q <= '0;
      fb_data_q <= '0;
    end else begin
      fb_valid_q <= fb_valid_d;
      hit_q <= hit_d;
      fb_tag_q <= fb_tag_d;
      fb_data_q <= fb_data_d;
    end
  end
`else
  assign fetch_ok = 1'b1;
  assign fb_ack = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sel_dat_d = sel_dat_q;
    idx_d = idx_q;
    oor_d = oor_q;
    we_d = we_q;
    wdata_d = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    if (accept) begin
      state_d = WAIT_STATES == 0 ? S_RESP : S_WAIT;
      cnt_d = WS;
      sel_dat_d = a_dat;
      idx_d = a_idx;
      oor_d = a_oor;
      we_d = a_we;
      wdata_d = a_wdata;
    end
    if (state_q == S_WAIT) begin
      cnt_d = cnt_q - 4'd1;
      state_d = cnt_q == 4'd1 ? S_RESP : S_WAIT;
    end
    if (state_q == S_RESP) state_d = S_IDLE;
    if (commit && !a_we && a_dat) d_rdata_d = rd_word;
    if (commit && !a_we && !a_dat) i_rdata_d = rd_word;
`ifdef UMEM_FETCH_BUF_EN
    if (hit_d) i_rdata_d = fb_data_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      sel_dat_q <= 1'b0;
      idx_q <= '0;
      oor_q <= 1'b0;
      we_q <= 1'b0;
      wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sel_dat_q <= sel_dat_d;
      idx_q <= idx_d;
      oor_q <= oor_d;
      we_q <= we_d;
      wdata_q <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end
  always_ff @(posedge clk) if (mem_we) mem[a_idx] <= a_wdata;
endmodule

// File: tb/tb_unified_mem_ctrl.sv
// tb_unified_mem_ctrl: directed self-checking bench for unified_mem_ctrl with WAIT_STATES=2
module tb_unified_mem_ctrl;
    localparam int WS = 2;
`ifdef UMEM_FETCH_BUF_EN
    localparam int HIT_LAT = 1;
    localparam logic HIT_BUSY = 1'b0;
`else
    localparam int HIT_LAT = WS + 1;
    localparam logic HIT_BUSY = 1'b1;
`endif
    logic clk = 1'b0, rst_n = 1'b0;
    logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic [31:0] i_rdata, d_rdata;
    logic i_ack, d_ack, addr_err, busy;
    int checks = 0, failures = 0;
    logic [31:0] rd;
    logic err, bsy;
    int lat;

    unified_mem_ctrl #(.DATA_W(32), .DEPTH(256), .WAIT_STATES(WS), .INIT_FILE("")) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .addr_err(addr_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that follows the ack cycle
    task automatic access(input logic dat, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic aerr, output logic bz, output int lt);
        if (dat) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        lt = -1; rdata = 'x; aerr = 1'bx; bz = 1'bx;
        for (int k = 0; k < 40 && lt < 0; k++) begin
            @(negedge clk);
            if (dat ? d_ack : i_ack) begin
                lt = k; rdata = dat ? d_rdata : i_rdata; aerr = addr_err; bz = busy;
            end
            @(posedge clk); #1;
        end
        d_req = 1'b0; i_req = 1'b0;
    endtask

    initial begin
        int d_first, i_first, overlap;
        logic [31:0] d_val, i_val;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_i_ack", i_ack, 0);
        check("rst_d_ack", d_ack, 0);
        check("rst_i_rdata", i_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_addr_err", addr_err, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        access(1, 1, 32'h0C, 32'hDEADBEEF, rd, err, bsy, lat);
        check("st0_lat", lat, WS + 1);
        check("st0_err", err, 0);
        check("st0_busy", bsy, 1);
        access(1, 1, 32'h00, 32'h11111111, rd, err, bsy, lat);
        access(1, 1, 32'h3FC, 32'h22222222, rd, err, bsy, lat);
        access(1, 1, 32'h08, 32'hCAFEF00D, rd, err, bsy, lat);
        access(1, 1, 32'h10, 32'h0BADF00D, rd, err, bsy, lat);
        access(1, 1, 32'h04, 32'h44444444, rd, err, bsy, lat);
        check("st_b2b_lat", lat, WS + 1);

        i_req = 1'b1; i_addr = 32'h0C;
        for (int k = 0; k <= WS + 2; k++) begin
            @(negedge clk);
            check($sformatf("f_busy_c%0d", k), busy, (k >= 1 && k <= WS + 1));
            check($sformatf("f_ack_c%0d", k), i_ack, k == WS + 1);
            if (k == WS + 1) check("f_rdata", i_rdata, 32'hDEADBEEF);
            @(posedge clk); #1;
            if (k == WS + 1) i_req = 1'b0;
        end

        access(1, 1, 32'h20, 32'h12345678, rd, err, bsy, lat);
        access(1, 0, 32'h20, 32'h0, rd, err, bsy, lat);
        check("ld20_data", rd, 32'h12345678);
        check("ld20_lat", lat, WS + 1);
        check("ld20_i_rdata", i_rdata, 32'hDEADBEEF);

        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h08; i_req = 1'b1; i_addr = 32'h10;
        d_first = -1; i_first = -1; overlap = 0; d_val = '0; i_val = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (d_ack && i_ack) overlap++;
            if (d_ack && d_first < 0) begin d_first = k; d_val = d_rdata; end
            if (i_ack && i_first < 0) begin i_first = k; i_val = i_rdata; end
            @(posedge clk); #1;
            if (k == d_first) d_req = 1'b0;
            if (k == i_first) i_req = 1'b0;
        end
        check("arb_d_cycle", d_first, WS + 1);
        check("arb_i_cycle", i_first, 2 * WS + 3);
        check("arb_overlap", overlap, 0);
        check("arb_d_data", d_val, 32'hCAFEF00D);
        check("arb_i_data", i_val, 32'h0BADF00D);

        access(1, 0, 32'h400, 32'h0, rd, err, bsy, lat);
        check("oor_ld_data", rd, 0);
        check("oor_ld_err", err, 1);
        access(1, 1, 32'h400, 32'hFFFFFFFF, rd, err, bsy, lat);
        check("oor_st_err", err, 1);
        access(1, 0, 32'h00, 32'h0, rd, err, bsy, lat);
        check("w0_data", rd, 32'h11111111);
        check("w0_err", err, 0);
        access(1, 0, 32'h3FC, 32'h0, rd, err, bsy, lat);
        check("w255_data", rd, 32'h22222222);

        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h08; d_wdata = 32'hAA;
        for (int k = 1; k <= WS; k++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0; d_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rstmid_d_ack", d_ack, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_d_rdata", d_rdata, 0);
        @(posedge clk); #1;
        access(1, 0, 32'h08, 32'h0, rd, err, bsy, lat);
        check("rstmid_ld08", rd, 32'hCAFEF00D);

        access(0, 0, 32'h04, 32'h0, rd, err, bsy, lat);
        check("fb1_lat", lat, WS + 1);
        check("fb1_data", rd, 32'h44444444);
        access(0, 0, 32'h04, 32'h0, rd, err, bsy, lat);
        check("fb2_lat", lat, HIT_LAT);
        check("fb2_busy", bsy, HIT_BUSY);
        check("fb2_data", rd, 32'h44444444);
        access(1, 1, 32'h04, 32'h55, rd, err, bsy, lat);
        access(0, 0, 32'h04, 32'h0, rd, err, bsy, lat);
        check("fb3_lat", lat, WS + 1);
        check("fb3_data", rd, 32'h55);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
